// File: rtl/local_branch_predictor.sv
// Two-level local branch predictor: per-bank local history table selects a
// 2-bit saturating counter; combinational prediction, synchronous training.

module local_branch_predictor_table #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_a_i,
  output logic [WIDTH-1:0]         rdata_a_o,
  input  logic [$clog2(DEPTH)-1:0] addr_b_i,
  output logic [WIDTH-1:0]         rdata_b_o,
  input  logic [WIDTH-1:0]         wdata_i
);

  // Unreset storage so contents survive reset and can be preloaded.
  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata_a_o = mem[addr_a_i];
  assign rdata_b_o = mem[addr_b_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_b_i] <= wdata_i;
    end
  end

endmodule

module local_branch_predictor #(
  parameter int unsigned VLEN                       = 32,
  parameter int unsigned INSTR_PER_FETCH            = 2,
  parameter bit          RVC                        = 1'b1,
  parameter int unsigned LOCAL_PREDICTOR_INDEX_BITS = 5,
  parameter int unsigned LBP_ENTRIES                = 64,
  parameter int unsigned LHR_ENTRIES                = 32
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic                                                   debug_mode_i,
  input  logic                                                   flush_bp_i,
  input  logic [VLEN-1:0]                                        vpc_i,
  // {valid, pc[VLEN], taken, index[H]}
  input  logic [VLEN+LOCAL_PREDICTOR_INDEX_BITS+1:0]             bht_update_i,
  // slot b at [b*(H+2) +: H+2], each {valid, taken, index[H]}
  output logic [INSTR_PER_FETCH*(LOCAL_PREDICTOR_INDEX_BITS+2)-1:0] bht_prediction_o
);

  localparam int unsigned H           = LOCAL_PREDICTOR_INDEX_BITS;
  localparam int unsigned I           = INSTR_PER_FETCH;
  localparam int unsigned NR_ROWS_LBP = LBP_ENTRIES / I;
  localparam int unsigned NR_ROWS_LHR = LHR_ENTRIES / I;
  localparam int unsigned OFF         = RVC ? 1 : 2;
  localparam int unsigned CB          = $clog2(I);
  localparam int unsigned CB_W        = (CB > 0) ? CB : 1;
  localparam int unsigned ROW_W       = $clog2(NR_ROWS_LHR);
  localparam int unsigned PRED_W      = H + 2;

  logic            upd_valid;
  logic [VLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [H-1:0]    upd_index;
  logic            upd_en;
  logic            pred_kill;
  logic [VLEN-1:0] upd_pc_sh;
  logic [VLEN-1:0] vpc_sh;
  logic [CB_W-1:0] upd_bank;
  logic [ROW_W-1:0] upd_row;
  logic [ROW_W-1:0] vpc_row;
  logic            unused_addr;

  assign upd_valid = bht_update_i[VLEN+H+1];
  assign upd_pc    = bht_update_i[H+1 +: VLEN];
  assign upd_taken = bht_update_i[H];
  assign upd_index = bht_update_i[H-1:0];

  assign upd_en    = upd_valid && !debug_mode_i && !flush_bp_i && !rst_i;
  assign pred_kill = rst_i || flush_bp_i;

  assign upd_pc_sh = upd_pc >> OFF;
  assign vpc_sh    = vpc_i >> OFF;
  assign upd_bank  = upd_pc_sh[CB_W-1:0];
  assign upd_row   = upd_pc_sh[CB +: ROW_W];
  assign vpc_row   = vpc_sh[CB +: ROW_W];

  assign unused_addr = ^{upd_pc_sh, vpc_sh};

  for (genvar b = 0; b < I; b++) begin : gen_bht_ram
    logic [H-1:0] pred_hist;
    logic [H-1:0] upd_hist;
    logic [2:0]   pred_entry;
    logic [2:0]   upd_entry;
    logic [1:0]   ctr_d;
    logic [H-1:0] hist_d;
    logic         bank_we;
    logic         unused_rd;

    assign bank_we = upd_en && ((I == 1) || (upd_bank == CB_W'(b)));

    // Counter steps from its stored value even when the entry is not yet valid.
    always_comb begin
      ctr_d = upd_entry[1:0];
      if (upd_taken) begin
        if (upd_entry[1:0] != 2'b11) ctr_d = upd_entry[1:0] + 2'b01;
      end else begin
        if (upd_entry[1:0] != 2'b00) ctr_d = upd_entry[1:0] - 2'b01;
      end
    end

    assign hist_d    = {upd_hist[H-2:0], upd_taken};
    assign unused_rd = ^{upd_hist[H-1], upd_entry[2]};

    local_branch_predictor_table #(
      .DEPTH (NR_ROWS_LHR),
      .WIDTH (H)
    ) i_lhr_ram (
      .clk_i     (clk_i),
      .we_i      (bank_we),
      .addr_a_i  (vpc_row),
      .rdata_a_o (pred_hist),
      .addr_b_i  (upd_row),
      .rdata_b_o (upd_hist),
      .wdata_i   (hist_d)
    );

    // Training uses the history captured at prediction time, not the live LHR.
    local_branch_predictor_table #(
      .DEPTH (NR_ROWS_LBP),
      .WIDTH (3)
    ) i_bht_ram (
      .clk_i     (clk_i),
      .we_i      (bank_we),
      .addr_a_i  (pred_hist),
      .rdata_a_o (pred_entry),
      .addr_b_i  (upd_index),
      .rdata_b_o (upd_entry),
      .wdata_i   ({1'b1, ctr_d})
    );

    always_comb begin
      bht_prediction_o[b*PRED_W +: PRED_W] = '0;
      if (!pred_kill) begin
        bht_prediction_o[b*PRED_W +: PRED_W] = {pred_entry[2], pred_entry[1], pred_hist};
      end
    end
  end

endmodule

// File: tb/tb_local_branch_predictor.sv
// Directed bench for local_branch_predictor: I=2, RVC, H=5, 16 LHR rows per bank.
// Bank = pc[1], LHR row = pc[5:2]; slot b of the output is bits [7b +: 7].

module tb_local_branch_predictor;

  localparam int unsigned VLEN = 32;
  localparam int unsigned H    = 5;

  logic              clk;
  logic              rst;
  logic              debug_mode;
  logic              flush_bp;
  logic [VLEN-1:0]   vpc;
  logic [VLEN+H+1:0] bht_update;
  logic [13:0]       pred;

  int n_vec;
  int n_err;

  logic [2:0]   bht_m [2][32];
  logic [H-1:0] lhr_m [2][16];

  local_branch_predictor #(
    .VLEN                       (VLEN),
    .INSTR_PER_FETCH            (2),
    .RVC                        (1'b1),
    .LOCAL_PREDICTOR_INDEX_BITS (H),
    .LBP_ENTRIES                (64),
    .LHR_ENTRIES                (32)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .debug_mode_i     (debug_mode),
    .flush_bp_i       (flush_bp),
    .vpc_i            (vpc),
    .bht_update_i     (bht_update),
    .bht_prediction_o (pred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_bht(input int b, input int idx, input logic [2:0] v);
    if (b == 0) dut.gen_bht_ram[0].i_bht_ram.mem[idx] = v;
    else        dut.gen_bht_ram[1].i_bht_ram.mem[idx] = v;
  endtask

  task automatic set_lhr(input int b, input int row, input logic [H-1:0] v);
    if (b == 0) dut.gen_bht_ram[0].i_lhr_ram.mem[row] = v;
    else        dut.gen_bht_ram[1].i_lhr_ram.mem[row] = v;
  endtask

  function automatic logic [2:0] get_bht(input int b, input int idx);
    if (b == 0) return dut.gen_bht_ram[0].i_bht_ram.mem[idx];
    return dut.gen_bht_ram[1].i_bht_ram.mem[idx];
  endfunction

  function automatic logic [H-1:0] get_lhr(input int b, input int row);
    if (b == 0) return dut.gen_bht_ram[0].i_lhr_ram.mem[row];
    return dut.gen_bht_ram[1].i_lhr_ram.mem[row];
  endfunction

  function automatic logic [6:0] model_pred(input int b, input logic [VLEN-1:0] pc);
    logic [3:0]   row;
    logic [H-1:0] h;
    logic [2:0]   e;
    row = pc[5:2];
    h   = lhr_m[b][row];
    e   = bht_m[b][h];
    return {e[2], e[1], h};
  endfunction

  // Called just after a rising edge; the write lands on the following edge.
  task automatic drive_update(input logic [VLEN-1:0] pc, input logic taken, input logic [H-1:0] idx);
    bht_update = {1'b1, pc, taken, idx};
    @(posedge clk);
    #1;
    bht_update = '0;
  endtask

  task automatic test_reset;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 32; i++) begin
        bht_m[b][i] = 3'($urandom_range(0, 7));
        set_bht(b, i, bht_m[b][i]);
      end
      for (int r = 0; r < 16; r++) begin
        lhr_m[b][r] = 5'($urandom_range(0, 31));
        set_lhr(b, r, lhr_m[b][r]);
      end
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      vpc = $urandom;
      @(negedge clk);
      n_vec++;
      if (pred !== 14'h0) begin
        n_err++;
        $display("FAIL reset_out: got %h expected %h", pred, 14'h0);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random_predict;
    repeat (2000) begin
      @(posedge clk);
      #1;
      vpc = $urandom;
      @(negedge clk);
      for (int b = 0; b < 2; b++) begin
        n_vec++;
        if (pred[b*7 +: 7] !== model_pred(b, vpc)) begin
          n_err++;
          $display("FAIL rand_pred slot%0d vpc=%h: got %h expected %h",
                   b, vpc, pred[b*7 +: 7], model_pred(b, vpc));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_counter;
    set_bht(0, 7, 3'b111);
    set_lhr(0, 2, 5'b00000);
    drive_update(32'h8, 1'b1, 5'd7);
    n_vec++;
    if (get_bht(0, 7) !== 3'b111) begin
      n_err++;
      $display("FAIL ctr_sat_hi: got %b expected %b", get_bht(0, 7), 3'b111);
    end
    n_vec++;
    if (get_lhr(0, 2) !== 5'b00001) begin
      n_err++;
      $display("FAIL ctr_sat_hi_lhr: got %b expected %b", get_lhr(0, 2), 5'b00001);
    end
    set_bht(0, 9, 3'b000);
    drive_update(32'h8, 1'b0, 5'd9);
    n_vec++;
    if (get_bht(0, 9) !== 3'b100) begin
      n_err++;
      $display("FAIL ctr_sat_lo: got %b expected %b", get_bht(0, 9), 3'b100);
    end
    n_vec++;
    if (get_lhr(0, 2) !== 5'b00010) begin
      n_err++;
      $display("FAIL ctr_sat_lo_lhr: got %b expected %b", get_lhr(0, 2), 5'b00010);
    end
  endtask

  task automatic test_same_cycle_flip;
    set_lhr(1, 4, 5'd12);
    set_bht(1, 12, 3'b101);
    vpc        = 32'h10;
    bht_update = {1'b1, 32'h16, 1'b1, 5'd12};
    @(negedge clk);
    n_vec++;
    if (pred[13:7] !== 7'b1001100) begin
      n_err++;
      $display("FAIL flip_old: got %b expected %b", pred[13:7], 7'b1001100);
    end
    @(posedge clk);
    #1;
    bht_update = '0;
    @(negedge clk);
    n_vec++;
    if (pred[13:7] !== 7'b1101100) begin
      n_err++;
      $display("FAIL flip_new: got %b expected %b", pred[13:7], 7'b1101100);
    end
    n_vec++;
    if (get_bht(1, 12) !== 3'b110) begin
      n_err++;
      $display("FAIL flip_ctr: got %b expected %b", get_bht(1, 12), 3'b110);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_history;
    set_lhr(1, 3, 5'b10110);
    set_lhr(0, 3, 5'b01010);
    set_bht(1, 0, 3'b010);
    set_bht(0, 0, 3'b001);
    drive_update(32'hE, 1'b1, 5'd0);
    n_vec++;
    if (get_lhr(1, 3) !== 5'b01101) begin
      n_err++;
      $display("FAIL hist_shift: got %b expected %b", get_lhr(1, 3), 5'b01101);
    end
    n_vec++;
    if (get_lhr(0, 3) !== 5'b01010) begin
      n_err++;
      $display("FAIL hist_other_bank: got %b expected %b", get_lhr(0, 3), 5'b01010);
    end
    n_vec++;
    if (get_bht(1, 0) !== 3'b111) begin
      n_err++;
      $display("FAIL hist_ctr: got %b expected %b", get_bht(1, 0), 3'b111);
    end
    n_vec++;
    if (get_bht(0, 0) !== 3'b001) begin
      n_err++;
      $display("FAIL hist_other_ctr: got %b expected %b", get_bht(0, 0), 3'b001);
    end
  endtask

  task automatic test_suppress;
    set_bht(0, 3, 3'b001);
    set_lhr(0, 6, 5'b00011);
    debug_mode = 1'b1;
    drive_update(32'h18, 1'b1, 5'd3);
    debug_mode = 1'b0;
    n_vec++;
    if (get_bht(0, 3) !== 3'b001 || get_lhr(0, 6) !== 5'b00011) begin
      n_err++;
      $display("FAIL debug_block: got %b/%b expected %b/%b",
               get_bht(0, 3), get_lhr(0, 6), 3'b001, 5'b00011);
    end
    set_lhr(1, 6, 5'd4);
    set_bht(1, 4, 3'b111);
    vpc        = 32'h18;
    flush_bp   = 1'b1;
    bht_update = {1'b1, 32'h18, 1'b1, 5'd3};
    @(negedge clk);
    n_vec++;
    if (pred !== 14'h0) begin
      n_err++;
      $display("FAIL flush_out: got %h expected %h", pred, 14'h0);
    end
    @(posedge clk);
    #1;
    bht_update = '0;
    flush_bp   = 1'b0;
    n_vec++;
    if (get_bht(0, 3) !== 3'b001 || get_lhr(0, 6) !== 5'b00011) begin
      n_err++;
      $display("FAIL flush_block: got %b/%b expected %b/%b",
               get_bht(0, 3), get_lhr(0, 6), 3'b001, 5'b00011);
    end
    @(negedge clk);
    n_vec++;
    if (pred !== {7'b1100100, 7'b0000011}) begin
      n_err++;
      $display("FAIL flush_release: got %b expected %b", pred, {7'b1100100, 7'b0000011});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    set_bht(0, 20, 3'b000);
    set_lhr(0, 7, 5'b00000);
    bht_update = {1'b1, 32'h1C, 1'b1, 5'd20};
    @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++;
    if (get_bht(0, 20) !== 3'b101 || get_lhr(0, 7) !== 5'b00001) begin
      n_err++;
      $display("FAIL b2b_first: got %b/%b expected %b/%b",
               get_bht(0, 20), get_lhr(0, 7), 3'b101, 5'b00001);
    end
    @(posedge clk);
    #1;
    bht_update = '0;
    n_vec++;
    if (get_bht(0, 20) !== 3'b110 || get_lhr(0, 7) !== 5'b00011) begin
      n_err++;
      $display("FAIL b2b_second: got %b/%b expected %b/%b",
               get_bht(0, 20), get_lhr(0, 7), 3'b110, 5'b00011);
    end
  endtask

  task automatic test_reset_midrun;
    set_lhr(0, 4, 5'd2);
    set_bht(0, 2, 3'b111);
    set_lhr(1, 4, 5'd12);
    set_bht(1, 12, 3'b110);
    vpc = 32'h10;
    @(negedge clk);
    n_vec++;
    if (pred !== {7'b1101100, 7'b1100010}) begin
      n_err++;
      $display("FAIL pre_reset: got %b expected %b", pred, {7'b1101100, 7'b1100010});
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (pred !== 14'h0) begin
      n_err++;
      $display("FAIL async_reset_out: got %h expected %h", pred, 14'h0);
    end
    bht_update = {1'b1, 32'h10, 1'b0, 5'd2};
    @(posedge clk);
    @(posedge clk);
    #1;
    bht_update = '0;
    n_vec++;
    if (get_bht(0, 2) !== 3'b111 || get_lhr(0, 4) !== 5'd2) begin
      n_err++;
      $display("FAIL reset_block: got %b/%b expected %b/%b",
               get_bht(0, 2), get_lhr(0, 4), 3'b111, 5'd2);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (pred !== {7'b1101100, 7'b1100010}) begin
      n_err++;
      $display("FAIL post_reset: got %b expected %b", pred, {7'b1101100, 7'b1100010});
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    debug_mode = 1'b0;
    flush_bp   = 1'b0;
    vpc        = '0;
    bht_update = '0;
    test_reset;
    test_random_predict;
    test_counter;
    test_same_cycle_flip;
    test_history;
    test_suppress;
    test_back_to_back;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
